// File: rtl/wb_burst_pkg.sv
// Shared encodings for the Wishbone B3 burst initiator: FSM states, CTI/BTE codes, select mask.
package wb_burst_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BURST = 2'd1,
      ST_RETRY = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_INCR    = 3'b010;
   localparam logic [2:0] CTI_EOB     = 3'b111;

   localparam logic [1:0] BTE_LINEAR  = 2'b00;
   localparam logic [3:0] SEL_WORD    = 4'hF;

   // Byte address to word address; the two low bits never reach the bus.
   function automatic logic [31:0] word_align(input logic [31:0] adr);
      return adr & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/wb_burst_initiator_if.sv
// Command, write/read streams and Wishbone B3 master bus of the burst initiator.
interface wb_burst_initiator_if #(
   parameter int unsigned LW = 4
);
   logic          cmd_valid;
   logic          cmd_ready;
   logic [31:0]   cmd_adr;
   logic [LW-1:0] cmd_len;
   logic          cmd_we;

   logic          wr_valid;
   logic          wr_ready;
   logic [31:0]   wr_data;

   logic          rd_valid;
   logic [31:0]   rd_data;
   logic          rd_last;

   logic          done;
   logic          done_err;

   logic [31:0]   wbm_adr_o;
   logic [31:0]   wbm_dat_o;
   logic [3:0]    wbm_sel_o;
   logic          wbm_we_o;
   logic          wbm_cyc_o;
   logic          wbm_stb_o;
   logic [2:0]    wbm_cti_o;
   logic [1:0]    wbm_bte_o;
   logic [31:0]   wbm_dat_i;
   logic          wbm_ack_i;
   logic          wbm_err_i;
   logic          wbm_rty_i;

   modport master (
      input  cmd_valid, cmd_adr, cmd_len, cmd_we,
      output cmd_ready,
      input  wr_valid, wr_data,
      output wr_ready,
      output rd_valid, rd_data, rd_last,
      output done, done_err,
      output wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o,
      output wbm_cyc_o, wbm_stb_o, wbm_cti_o, wbm_bte_o,
      input  wbm_dat_i, wbm_ack_i, wbm_err_i, wbm_rty_i
   );

   modport slave (
      output cmd_valid, cmd_adr, cmd_len, cmd_we,
      input  cmd_ready,
      output wr_valid, wr_data,
      input  wr_ready,
      input  rd_valid, rd_data, rd_last,
      input  done, done_err,
      input  wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o,
      input  wbm_cyc_o, wbm_stb_o, wbm_cti_o, wbm_bte_o,
      output wbm_dat_i, wbm_ack_i, wbm_err_i, wbm_rty_i
   );

endinterface

// File: rtl/wb_burst_initiator.sv
// Wishbone B3 incrementing-burst master: one command -> 1..MAX_BEATS beats, read data one cycle after ack.
// Writes stall on wr_valid (stb drops); reads have no backpressure; err aborts, rty re-presents the beat.
module wb_burst_initiator
   import wb_burst_pkg::*;
#(
   parameter int unsigned MAX_BEATS = 16,
   parameter int unsigned LW        = $clog2(MAX_BEATS)
) (
   input  logic                 wb_clk,
   input  logic                 wb_rst_n,
   wb_burst_initiator_if.master bus
);

   if (MAX_BEATS < 2 || MAX_BEATS > 256 || (MAX_BEATS & (MAX_BEATS - 1)) != 0 ||
       LW != $clog2(MAX_BEATS)) begin : g_param_check
      $error("wb_burst_initiator: MAX_BEATS must be a power of two in 2..256 with LW = clog2(MAX_BEATS)");
   end

   state_e        state_q, state_d;
   logic [31:0]   adr_q, adr_d;
   logic [LW:0]   cnt_q, cnt_d;
   logic          we_q, we_d;
   logic          err_q, err_d;
   logic          rd_valid_q, rd_valid_d;
   logic [31:0]   rd_data_q, rd_data_d;
   logic          rd_last_q, rd_last_d;

   logic          in_burst;
   logic          stb;
   logic          last_beat;
   logic          bus_err;
   logic          bus_rty;
   logic          bus_ack;

   assign in_burst  = (state_q == ST_BURST);
   assign stb       = in_burst && (we_q ? bus.wr_valid : 1'b1);
   assign last_beat = (cnt_q == {{LW{1'b0}}, 1'b1});

   // Responses only count while strobing; err beats rty beats ack.
   assign bus_err = stb & bus.wbm_err_i;
   assign bus_rty = stb & ~bus.wbm_err_i & bus.wbm_rty_i;
   assign bus_ack = stb & ~bus.wbm_err_i & ~bus.wbm_rty_i & bus.wbm_ack_i;

   always_comb begin
      state_d    = state_q;
      adr_d      = adr_q;
      cnt_d      = cnt_q;
      we_d       = we_q;
      err_d      = err_q;
      rd_valid_d = 1'b0;
      rd_data_d  = rd_data_q;
      rd_last_d  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (bus.cmd_valid) begin
               adr_d   = word_align(bus.cmd_adr);
               cnt_d   = {1'b0, bus.cmd_len} + {{LW{1'b0}}, 1'b1};
               we_d    = bus.cmd_we;
               err_d   = 1'b0;
               state_d = ST_BURST;
            end
         end
         ST_BURST: begin
            if (bus_err) begin
               err_d   = 1'b1;
               state_d = ST_DONE;
            end else if (bus_rty) begin
               state_d = ST_RETRY;
            end else if (bus_ack) begin
               adr_d = adr_q + 32'd4;
               cnt_d = cnt_q - {{LW{1'b0}}, 1'b1};
               if (!we_q) begin
                  rd_valid_d = 1'b1;
                  rd_data_d  = bus.wbm_dat_i;
                  rd_last_d  = last_beat;
               end
               if (last_beat) begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_RETRY: state_d = ST_BURST;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge wb_clk or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         state_q    <= ST_IDLE;
         adr_q      <= 32'd0;
         cnt_q      <= '0;
         we_q       <= 1'b0;
         err_q      <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= 32'd0;
         rd_last_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         adr_q      <= adr_d;
         cnt_q      <= cnt_d;
         we_q       <= we_d;
         err_q      <= err_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
         rd_last_q  <= rd_last_d;
      end
   end

   assign bus.cmd_ready = (state_q == ST_IDLE);

   assign bus.wbm_cyc_o = in_burst;
   assign bus.wbm_stb_o = stb;
   assign bus.wbm_we_o  = we_q;
   assign bus.wbm_adr_o = adr_q;
   assign bus.wbm_sel_o = SEL_WORD;
   assign bus.wbm_bte_o = BTE_LINEAR;
   assign bus.wbm_cti_o = in_burst ? (last_beat ? CTI_EOB : CTI_INCR) : CTI_CLASSIC;
   assign bus.wbm_dat_o = bus.wr_data;

   assign bus.wr_ready  = bus_ack & we_q;

   assign bus.rd_valid  = rd_valid_q;
   assign bus.rd_data   = rd_data_q;
   assign bus.rd_last   = rd_last_q;

   assign bus.done      = (state_q == ST_DONE);
   assign bus.done_err  = (state_q == ST_DONE) & err_q;

endmodule
